// File: rtl/AHBCommon_pkg.sv
// Shared AHB constants and manager state encoding.
package AHBCommon_pkg;

    localparam int unsigned TransWidth = 2;

    localparam logic [TransWidth-1:0] TRANS_IDLE   = 2'b00;
    localparam logic [TransWidth-1:0] TRANS_NONSEQ = 2'b10;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        MGR_IDLE = 2'd0,
        MGR_ADDR = 2'd1,
        MGR_DATA = 2'd2,
        MGR_ERR  = 2'd3
    } mgr_state_t;

endpackage

// File: rtl/ahb_mgr_cmd_slot.sv
// One-entry command holding register (write, address, write data, valid).
module ahb_mgr_cmd_slot #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 i_load,
    input  logic                 i_clear,
    input  logic                 i_write,
    input  logic [AddrWidth-1:0] i_addr,
    input  logic [DataWidth-1:0] i_wdata,
    output logic                 o_valid,
    output logic                 o_write,
    output logic [AddrWidth-1:0] o_addr,
    output logic [DataWidth-1:0] o_wdata
);

    logic                 r_valid;
    logic                 r_write;
    logic [AddrWidth-1:0] r_addr;
    logic [DataWidth-1:0] r_wdata;

    // Capture a command on load; load wins over clear.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_valid <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_write <= i_write;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_write = r_write;
    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;

endmodule

// File: rtl/ahb_manager.sv
// Single-transfer AHB manager: valid/ready command port in, NONSEQ transfers
// out, one in-order response pulse per command. Wait states and the two-cycle
// ERROR response are honoured.
// Define AHB_MGR_PIPELINE_EN to overlap the next address phase with the
// current data phase through a one-entry pending slot.
module ahb_manager
    import AHBCommon_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic                  cmdValid,
    output logic                  cmdReady,
    input  logic                  cmdWrite,
    input  logic [AddrWidth-1:0]  cmdAddr,
    input  logic [DataWidth-1:0]  cmdWData,
    output logic                  rspValid,
    output logic                  rspErr,
    output logic [DataWidth-1:0]  rspData,
    output logic [AddrWidth-1:0]  addr,
    output logic                  write,
    output logic [TransWidth-1:0] trans,
    output logic [DataWidth-1:0]  wData,
    input  logic [DataWidth-1:0]  rData,
    input  logic                  ready,
    input  logic                  resp
);

    mgr_state_t            r_state;
    logic [AddrWidth-1:0]  r_addr;
    logic                  r_write;
    logic [TransWidth-1:0] r_trans;
    logic [DataWidth-1:0]  r_wdata;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [DataWidth-1:0]  r_rsp_data;
    // Attributes of the transfer currently owning the address/data phase
    logic                  r_cur_write;
    logic [DataWidth-1:0]  r_cur_wdata;

    logic                  w_accept;
    logic                  w_pend;
    logic                  w_pend_write;
    logic [AddrWidth-1:0]  w_pend_addr;
    logic [DataWidth-1:0]  w_pend_wdata;

    assign w_accept = cmdValid && cmdReady;

`ifdef AHB_MGR_PIPELINE_EN
    logic w_slot_load;
    logic w_slot_clear;

    // Park a command accepted while the current data phase is still waiting.
    assign w_slot_load  = w_accept && (r_state == MGR_DATA) && !ready;
    assign w_slot_clear = w_pend && ready &&
                          ((r_state == MGR_DATA) || (r_state == MGR_ERR));

    ahb_mgr_cmd_slot #(
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth)
    ) u_pend_slot (
        .clk     (clk),
        .nReset  (nReset),
        .i_load  (w_slot_load),
        .i_clear (w_slot_clear),
        .i_write (cmdWrite),
        .i_addr  (cmdAddr),
        .i_wdata (cmdWData),
        .o_valid (w_pend),
        .o_write (w_pend_write),
        .o_addr  (w_pend_addr),
        .o_wdata (w_pend_wdata)
    );
`else
    assign w_pend       = 1'b0;
    assign w_pend_write = 1'b0;
    assign w_pend_addr  = '0;
    assign w_pend_wdata = '0;
`endif

    // Command port ready decoded from state, held low during reset.
    always_comb begin
        cmdReady = 1'b0;
        if (nReset) begin
            if (r_state == MGR_IDLE) begin
                cmdReady = 1'b1;
            end
`ifdef AHB_MGR_PIPELINE_EN
            else if (r_state == MGR_DATA) begin
                cmdReady = !w_pend;
            end
`endif
        end
    end

    // Transfer sequencing with registered bus and response outputs.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_state     <= MGR_IDLE;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_trans     <= TRANS_IDLE;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_cur_write <= 1'b0;
            r_cur_wdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                MGR_IDLE: begin
                    if (w_accept) begin
                        r_addr      <= cmdAddr;
                        r_write     <= cmdWrite;
                        r_trans     <= TRANS_NONSEQ;
                        r_cur_write <= cmdWrite;
                        r_cur_wdata <= cmdWData;
                        r_state     <= MGR_ADDR;
                    end
                end
                MGR_ADDR: begin
                    if (ready) begin
                        r_trans <= TRANS_IDLE;
                        r_wdata <= r_cur_wdata;
                        r_state <= MGR_DATA;
                    end
                end
                MGR_DATA: begin
                    if (ready) begin
                        // Completion; a single-cycle ERROR also ends here
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= (resp == RESP_ERROR);
                        r_rsp_data  <= ((resp == RESP_OKAY) && !r_cur_write) ? rData : '0;
                        if (w_pend) begin
                            // Pending address phase completes on this edge too
                            r_trans     <= TRANS_IDLE;
                            r_wdata     <= w_pend_wdata;
                            r_cur_write <= w_pend_write;
                        end else if (w_accept) begin
                            r_addr      <= cmdAddr;
                            r_write     <= cmdWrite;
                            r_trans     <= TRANS_NONSEQ;
                            r_cur_write <= cmdWrite;
                            r_cur_wdata <= cmdWData;
                            r_state     <= MGR_ADDR;
                        end else begin
                            r_state <= MGR_IDLE;
                        end
                    end else if (resp == RESP_ERROR) begin
                        // First ERROR cycle: cancel any address on the bus
                        r_trans <= TRANS_IDLE;
                        r_state <= MGR_ERR;
                    end else if (w_accept) begin
                        r_addr  <= cmdAddr;
                        r_write <= cmdWrite;
                        r_trans <= TRANS_NONSEQ;
                    end
                end
                MGR_ERR: begin
                    if (ready) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_data  <= '0;
                        if (w_pend) begin
                            r_addr      <= w_pend_addr;
                            r_write     <= w_pend_write;
                            r_trans     <= TRANS_NONSEQ;
                            r_cur_write <= w_pend_write;
                            r_cur_wdata <= w_pend_wdata;
                            r_state     <= MGR_ADDR;
                        end else begin
                            r_state <= MGR_IDLE;
                        end
                    end
                end
                default: r_state <= MGR_IDLE;
            endcase
        end
    end

    assign addr     = r_addr;
    assign write    = r_write;
    assign trans    = r_trans;
    assign wData    = r_wdata;
    assign rspValid = r_rsp_valid;
    assign rspErr   = r_rsp_err;
    assign rspData  = r_rsp_data;

endmodule

// File: tb/tb_ahb_manager.sv
// Bench for ahb_manager: bus responses are driven cycle by cycle, expected
// responses (error flag, data, arrival cycle) are queued as commands are
// offered and matched by a response monitor. AHB_MGR_PIPELINE_EN adds the
// overlap scenarios.
module tb_ahb_manager;
    import AHBCommon_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
`ifdef AHB_MGR_PIPELINE_EN
    localparam int Spacing = 2;
`else
    localparam int Spacing = 3;
`endif

    logic          clk      = 1'b0;
    logic          nReset   = 1'b0;
    logic          cmdValid = 1'b0;
    logic          cmdReady;
    logic          cmdWrite = 1'b0;
    logic [AW-1:0] cmdAddr  = '0;
    logic [DW-1:0] cmdWData = '0;
    logic          rspValid;
    logic          rspErr;
    logic [DW-1:0] rspData;
    logic [AW-1:0] addr;
    logic          write;
    logic [1:0]    trans;
    logic [DW-1:0] wData;
    logic [DW-1:0] rData    = '0;
    logic          ready    = 1'b1;
    logic          resp     = RESP_OKAY;

    int errors  = 0;
    int checks  = 0;
    int cyc_cnt = 0;

    typedef struct {
        logic          err;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t sb[$];

    ahb_manager #(.AddrWidth(AW), .DataWidth(DW)) dut (
        .clk      (clk),
        .nReset   (nReset),
        .cmdValid (cmdValid),
        .cmdReady (cmdReady),
        .cmdWrite (cmdWrite),
        .cmdAddr  (cmdAddr),
        .cmdWData (cmdWData),
        .rspValid (rspValid),
        .rspErr   (rspErr),
        .rspData  (rspData),
        .addr     (addr),
        .write    (write),
        .trans    (trans),
        .wData    (wData),
        .rData    (rData),
        .ready    (ready),
        .resp     (resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Response monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rspValid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: rspValid=1 at cycle %0d, required no response", cyc_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (cyc_cnt !== e.cyc) begin
                    errors++;
                    $display("FAIL rsp_cycle: got %0d required %0d", cyc_cnt, e.cyc);
                end
                checks++;
                if (rspErr !== e.err) begin
                    errors++;
                    $display("FAIL rsp_err: got %0b required %0b", rspErr, e.err);
                end
                checks++;
                if (rspData !== e.data) begin
                    errors++;
                    $display("FAIL rsp_data: got %h required %h", rspData, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++; if (trans !== TRANS_IDLE) begin errors++; $display("FAIL rst_trans: got %b required %b", trans, TRANS_IDLE); end
        checks++; if (addr !== '0) begin errors++; $display("FAIL rst_addr: got %h required 0", addr); end
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL rst_write: got %b required 0", write); end
        checks++; if (wData !== '0) begin errors++; $display("FAIL rst_wdata: got %h required 0", wData); end
        checks++; if (rspValid !== 1'b0) begin errors++; $display("FAIL rst_rspvalid: got %b required 0", rspValid); end
        checks++; if (rspErr !== 1'b0) begin errors++; $display("FAIL rst_rsperr: got %b required 0", rspErr); end
        checks++; if (rspData !== '0) begin errors++; $display("FAIL rst_rspdata: got %h required 0", rspData); end
        checks++; if (cmdReady !== 1'b0) begin errors++; $display("FAIL rst_cmdready_low: got %b required 0", cmdReady); end
        tick();
        nReset = 1'b1;
        @(negedge clk);
        checks++; if (cmdReady !== 1'b1) begin errors++; $display("FAIL rst_cmdready_idle: got %b required 1", cmdReady); end
        tick();
    endtask

    task automatic test_write();
        int e;
        cmdValid = 1'b1; cmdWrite = 1'b1; cmdAddr = 32'h10; cmdWData = 32'hDEADBEEF;
        rData = 32'hFFFF0000; ready = 1'b1; resp = RESP_OKAY;
        e = cyc_cnt + 1;
        sb.push_back('{err: 1'b0, data: '0, cyc: e + 2});
        @(negedge clk);
        checks++; if (cmdReady !== 1'b1) begin errors++; $display("FAIL wr_cmdready: got %b required 1", cmdReady); end
        tick();
        cmdValid = 1'b0; cmdWData = '0;
        @(negedge clk);
        checks++; if (trans !== TRANS_NONSEQ) begin errors++; $display("FAIL wr_trans_c1: got %b required %b", trans, TRANS_NONSEQ); end
        checks++; if (addr !== 32'h10) begin errors++; $display("FAIL wr_addr_c1: got %h required 00000010", addr); end
        checks++; if (write !== 1'b1) begin errors++; $display("FAIL wr_write_c1: got %b required 1", write); end
        checks++; if (cmdReady !== 1'b0) begin errors++; $display("FAIL wr_cmdready_busy: got %b required 0", cmdReady); end
        tick();
        @(negedge clk);
        checks++; if (trans !== TRANS_IDLE) begin errors++; $display("FAIL wr_trans_c2: got %b required %b", trans, TRANS_IDLE); end
        checks++; if (wData !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_wdata_c2: got %h required deadbeef", wData); end
        tick();
        @(negedge clk);
        checks++; if (rspValid !== 1'b1) begin errors++; $display("FAIL wr_rspvalid_c3: got %b required 1", rspValid); end
        tick();
        rData = '0;
    endtask

    task automatic test_read_wait();
        int e;
        cmdValid = 1'b1; cmdWrite = 1'b0; cmdAddr = 32'h20; cmdWData = 32'h0;
        e = cyc_cnt + 1;
        sb.push_back('{err: 1'b0, data: 32'h12345678, cyc: e + 4});
        tick();
        cmdValid = 1'b0;
        @(negedge clk);
        checks++; if (addr !== 32'h20 || write !== 1'b0) begin errors++; $display("FAIL rd_addr_c1: got %h/%b required 00000020/0", addr, write); end
        tick();
        ready = 1'b0; rData = 32'hBAD0BAD0;
        @(negedge clk);
        checks++; if (rspValid !== 1'b0) begin errors++; $display("FAIL rd_wait1_rsp: got %b required 0", rspValid); end
        tick();
        @(negedge clk);
        checks++; if (rspValid !== 1'b0) begin errors++; $display("FAIL rd_wait2_rsp: got %b required 0", rspValid); end
        tick();
        ready = 1'b1; rData = 32'h12345678;
        tick();
        rData = '0;
        @(negedge clk);
        checks++; if (rspValid !== 1'b1) begin errors++; $display("FAIL rd_rspvalid_c5: got %b required 1", rspValid); end
        tick();
        @(negedge clk);
        checks++; if (rspValid !== 1'b0) begin errors++; $display("FAIL rd_single_pulse: got %b required 0", rspValid); end
        tick();
    endtask

    task automatic test_error();
        int e;
        cmdValid = 1'b1; cmdWrite = 1'b0; cmdAddr = 32'h30;
        e = cyc_cnt + 1;
        sb.push_back('{err: 1'b1, data: '0, cyc: e + 3});
        tick();
        cmdValid = 1'b0;
        tick();
        resp = RESP_ERROR; ready = 1'b0; rData = 32'hA5A5A5A5;
        @(negedge clk);
        checks++; if (trans !== TRANS_IDLE) begin errors++; $display("FAIL err_trans_1st: got %b required %b", trans, TRANS_IDLE); end
        tick();
        ready = 1'b1;
        @(negedge clk);
        checks++; if (trans !== TRANS_IDLE) begin errors++; $display("FAIL err_trans_2nd: got %b required %b", trans, TRANS_IDLE); end
        tick();
        resp = RESP_OKAY; rData = '0;
        @(negedge clk);
        checks++; if (rspErr !== 1'b1) begin errors++; $display("FAIL err_rsperr: got %b required 1", rspErr); end
        tick();
    endtask

    task automatic test_back_to_back();
        int e0;
        int idx;
        logic acc;
        idx = 0;
        e0 = cyc_cnt + 1;
        for (int k = 0; k < 3; k++) sb.push_back('{err: 1'b0, data: '0, cyc: e0 + 2 + k * Spacing});
        cmdValid = 1'b1; cmdWrite = 1'b1;
        cmdAddr = 32'h100; cmdWData = 32'hC0DE0000;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            acc = cmdValid && cmdReady;
            tick();
            if (acc && idx < 3) idx++;
            if (idx >= 3) begin
                cmdValid = 1'b0;
            end else begin
                cmdAddr  = 32'h100 + 32'(idx * 4);
                cmdWData = 32'hC0DE0000 + 32'(idx);
            end
        end
        checks++; if (idx !== 3) begin errors++; $display("FAIL b2b_accepts: got %0d required 3", idx); end
    endtask

`ifdef AHB_MGR_PIPELINE_EN
    task automatic test_pipe_wait();
        int e;
        cmdValid = 1'b1; cmdWrite = 1'b1; cmdAddr = 32'h200; cmdWData = 32'hAAAA0001;
        e = cyc_cnt + 1;
        sb.push_back('{err: 1'b0, data: '0, cyc: e + 4});
        sb.push_back('{err: 1'b0, data: '0, cyc: e + 5});
        tick();
        cmdAddr = 32'h204; cmdWData = 32'hBBBB0002;
        @(negedge clk);
        checks++; if (cmdReady !== 1'b0) begin errors++; $display("FAIL pw_ready_addr: got %b required 0", cmdReady); end
        tick();
        ready = 1'b0;
        @(negedge clk);
        checks++; if (cmdReady !== 1'b1) begin errors++; $display("FAIL pw_ready_data: got %b required 1", cmdReady); end
        tick();
        cmdValid = 1'b0;
        @(negedge clk);
        checks++; if (addr !== 32'h204 || trans !== TRANS_NONSEQ) begin errors++; $display("FAIL pw_pend_addr: got %h/%b required 00000204/%b", addr, trans, TRANS_NONSEQ); end
        checks++; if (cmdReady !== 1'b0) begin errors++; $display("FAIL pw_ready_pend: got %b required 0", cmdReady); end
        tick();
        ready = 1'b1;
        @(negedge clk);
        checks++; if (addr !== 32'h204 || trans !== TRANS_NONSEQ) begin errors++; $display("FAIL pw_addr_held: got %h/%b required 00000204/%b", addr, trans, TRANS_NONSEQ); end
        tick();
        @(negedge clk);
        checks++; if (trans !== TRANS_IDLE || wData !== 32'hBBBB0002) begin errors++; $display("FAIL pw_b_data: got %b/%h required %b/bbbb0002", trans, wData, TRANS_IDLE); end
        tick();
        tick();
    endtask

    task automatic test_pipe_error();
        int e;
        cmdValid = 1'b1; cmdWrite = 1'b1; cmdAddr = 32'h300; cmdWData = 32'h11111111;
        e = cyc_cnt + 1;
        sb.push_back('{err: 1'b1, data: '0, cyc: e + 4});
        sb.push_back('{err: 1'b0, data: '0, cyc: e + 6});
        tick();
        cmdAddr = 32'h304; cmdWData = 32'h22222222;
        tick();
        ready = 1'b0;
        tick();
        cmdValid = 1'b0; resp = RESP_ERROR;
        @(negedge clk);
        checks++; if (trans !== TRANS_NONSEQ || addr !== 32'h304) begin errors++; $display("FAIL pe_pend_on_bus: got %b/%h required %b/00000304", trans, addr, TRANS_NONSEQ); end
        tick();
        ready = 1'b1;
        @(negedge clk);
        checks++; if (trans !== TRANS_IDLE) begin errors++; $display("FAIL pe_trans_cancel: got %b required %b", trans, TRANS_IDLE); end
        tick();
        resp = RESP_OKAY;
        @(negedge clk);
        checks++; if (trans !== TRANS_NONSEQ || addr !== 32'h304) begin errors++; $display("FAIL pe_reissue: got %b/%h required %b/00000304", trans, addr, TRANS_NONSEQ); end
        tick();
        @(negedge clk);
        checks++; if (wData !== 32'h22222222) begin errors++; $display("FAIL pe_b_wdata: got %h required 22222222", wData); end
        tick();
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        cmdValid = 1'b1; cmdWrite = 1'b0; cmdAddr = 32'h40; cmdWData = 32'h5555AAAA;
        tick();
        cmdValid = 1'b0;
        tick();
        ready = 1'b0;
        tick();
        nReset = 1'b0;
        @(negedge clk);
        checks++; if (cmdReady !== 1'b0) begin errors++; $display("FAIL rm_cmdready_rst: got %b required 0", cmdReady); end
        tick();
        nReset = 1'b1; ready = 1'b1;
        @(negedge clk);
        checks++; if (trans !== TRANS_IDLE || addr !== '0 || write !== 1'b0) begin errors++; $display("FAIL rm_bus: got %b/%h/%b required %b/0/0", trans, addr, write, TRANS_IDLE); end
        checks++; if (wData !== '0) begin errors++; $display("FAIL rm_wdata: got %h required 0", wData); end
        checks++; if (rspValid !== 1'b0 || rspErr !== 1'b0 || rspData !== '0) begin errors++; $display("FAIL rm_rsp: got %b/%b/%h required 0/0/0", rspValid, rspErr, rspData); end
        checks++; if (cmdReady !== 1'b1) begin errors++; $display("FAIL rm_cmdready: got %b required 1", cmdReady); end
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_error();
        test_back_to_back();
`ifdef AHB_MGR_PIPELINE_EN
        test_pipe_wait();
        test_pipe_error();
`endif
        test_reset_mid();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d outstanding responses required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
